// File: rtl/mmc_dat_rx.sv
// DAT0 receive path for 1-bit MMC mode: start-bit hunt, MSB-first byte
// deserialisation, CRC16-CCITT accumulation, trailing CRC capture and end-bit check.
module mmc_dat_rx #(
  parameter int BLOCK_BYTES = 512,
  parameter int TIMEOUT     = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic       dat_i,
  input  logic       rx_start,
  output logic       busy,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  output logic       done,
  output logic       crc_ok,
  output logic       crc_err,
  output logic       end_err,
  output logic       timeout
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CRC   = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  localparam logic [11:0] LAST_BYTE = 12'(BLOCK_BYTES - 1);
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  logic [2:0]  state_reg,    state_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic [2:0]  bit_cnt_reg,  bit_cnt_next;
  logic [11:0] byte_cnt_reg, byte_cnt_next;
  logic [3:0]  crc_cnt_reg,  crc_cnt_next;
  logic [7:0]  shift_reg,    shift_next;
  logic [15:0] crc_reg,      crc_next;
  logic [15:0] rx_crc_reg,   rx_crc_next;
  logic        busy_reg,     busy_next;
  logic [7:0]  byte_out_reg, byte_out_next;
  logic        byte_vld_reg, byte_vld_next;
  logic        done_reg,     done_next;
  logic        crc_ok_reg,   crc_ok_next;
  logic        crc_err_reg,  crc_err_next;
  logic        end_err_reg,  end_err_next;
  logic        timeout_reg,  timeout_next;

  logic [7:0]  shift_in;
  logic [15:0] crc_step;

  // One serial step of x^16+x^12+x^5+1, MSB-first.
  always_comb begin
    crc_step = {crc_reg[14:0], 1'b0};
    if (dat_i ^ crc_reg[15]) begin
      crc_step = crc_step ^ 16'h1021;
    end
  end

  assign shift_in = {shift_reg[6:0], dat_i};

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    crc_cnt_next  = crc_cnt_reg;
    shift_next    = shift_reg;
    crc_next      = crc_reg;
    rx_crc_next   = rx_crc_reg;
    busy_next     = busy_reg;
    byte_out_next = byte_out_reg;
    byte_vld_next = 1'b0;
    done_next     = 1'b0;
    crc_ok_next   = crc_ok_reg;
    crc_err_next  = crc_err_reg;
    end_err_next  = end_err_reg;
    timeout_next  = timeout_reg;

    case (state_reg)
      ST_IDLE: begin
        if (rx_start) begin
          state_next    = ST_WAIT;
          crc_next      = 16'h0000;
          crc_ok_next   = 1'b0;
          crc_err_next  = 1'b0;
          end_err_next  = 1'b0;
          timeout_next  = 1'b0;
          wait_cnt_next = 16'h0000;
          busy_next     = 1'b1;
        end
      end

      ST_WAIT: begin
        if (bit_en) begin
          if (!dat_i) begin
            state_next    = ST_DATA;
            bit_cnt_next  = 3'd7;
            byte_cnt_next = 12'd0;
          end else if (wait_cnt_reg == LAST_WAIT) begin
            state_next   = ST_IDLE;
            timeout_next = 1'b1;
            done_next    = 1'b1;
            busy_next    = 1'b0;
          end else begin
            wait_cnt_next = wait_cnt_reg + 16'd1;
          end
        end
      end

      ST_DATA: begin
        if (bit_en) begin
          shift_next = shift_in;
          crc_next   = crc_step;
          if (bit_cnt_reg == 3'd0) begin
            byte_out_next = shift_in;
            byte_vld_next = 1'b1;
            bit_cnt_next  = 3'd7;
            if (byte_cnt_reg == LAST_BYTE) begin
              state_next   = ST_CRC;
              crc_cnt_next = 4'd15;
            end else begin
              byte_cnt_next = byte_cnt_reg + 12'd1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg - 3'd1;
          end
        end
      end

      ST_CRC: begin
        // The computed CRC stays frozen while the card's copy shifts in.
        if (bit_en) begin
          rx_crc_next = {rx_crc_reg[14:0], dat_i};
          if (crc_cnt_reg == 4'd0) begin
            state_next = ST_END;
          end else begin
            crc_cnt_next = crc_cnt_reg - 4'd1;
          end
        end
      end

      ST_END: begin
        if (bit_en) begin
          crc_err_next = (rx_crc_reg != crc_reg);
          end_err_next = ~dat_i;
          crc_ok_next  = (rx_crc_reg == crc_reg) & dat_i;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 16'h0000;
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= 12'd0;
      crc_cnt_reg  <= 4'd0;
      shift_reg    <= 8'h00;
      crc_reg      <= 16'h0000;
      rx_crc_reg   <= 16'h0000;
      busy_reg     <= 1'b0;
      byte_out_reg <= 8'h00;
      byte_vld_reg <= 1'b0;
      done_reg     <= 1'b0;
      crc_ok_reg   <= 1'b0;
      crc_err_reg  <= 1'b0;
      end_err_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      crc_cnt_reg  <= crc_cnt_next;
      shift_reg    <= shift_next;
      crc_reg      <= crc_next;
      rx_crc_reg   <= rx_crc_next;
      busy_reg     <= busy_next;
      byte_out_reg <= byte_out_next;
      byte_vld_reg <= byte_vld_next;
      done_reg     <= done_next;
      crc_ok_reg   <= crc_ok_next;
      crc_err_reg  <= crc_err_next;
      end_err_reg  <= end_err_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign busy     = busy_reg;
  assign byte_out = byte_out_reg;
  assign byte_vld = byte_vld_reg;
  assign done     = done_reg;
  assign crc_ok   = crc_ok_reg;
  assign crc_err  = crc_err_reg;
  assign end_err  = end_err_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_mmc_dat_rx.sv
// Bench for mmc_dat_rx: a 512-byte instance and a 9-byte/TIMEOUT=100 instance,
// checked against a byte-oriented CRC16 reference and a received-byte scoreboard.
module tb_mmc_dat_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bit_en = 1'b0;
  logic dat_i = 1'b1;
  logic rx_start_a = 1'b0;
  logic rx_start_b = 1'b0;

  logic       a_busy, a_byte_vld, a_done, a_crc_ok, a_crc_err, a_end_err, a_timeout;
  logic [7:0] a_byte_out;
  logic       b_busy, b_byte_vld, b_done, b_crc_ok, b_crc_err, b_end_err, b_timeout;
  logic [7:0] b_byte_out;

  mmc_dat_rx #(.BLOCK_BYTES(512), .TIMEOUT(65535)) dut_a (
    .clk(clk), .rst(rst), .bit_en(bit_en), .dat_i(dat_i), .rx_start(rx_start_a),
    .busy(a_busy), .byte_out(a_byte_out), .byte_vld(a_byte_vld), .done(a_done),
    .crc_ok(a_crc_ok), .crc_err(a_crc_err), .end_err(a_end_err), .timeout(a_timeout)
  );

  mmc_dat_rx #(.BLOCK_BYTES(9), .TIMEOUT(100)) dut_b (
    .clk(clk), .rst(rst), .bit_en(bit_en), .dat_i(dat_i), .rx_start(rx_start_b),
    .busy(b_busy), .byte_out(b_byte_out), .byte_vld(b_byte_vld), .done(b_done),
    .crc_ok(b_crc_ok), .crc_err(b_crc_err), .end_err(b_end_err), .timeout(b_timeout)
  );

  always #5 clk = ~clk;

  logic       sel = 1'b0;  // 0 observes dut_a, 1 observes dut_b
  logic       o_busy, o_byte_vld, o_done, o_crc_ok, o_crc_err, o_end_err, o_timeout;
  logic [7:0] o_byte_out;
  assign o_busy     = sel ? b_busy     : a_busy;
  assign o_byte_out = sel ? b_byte_out : a_byte_out;
  assign o_byte_vld = sel ? b_byte_vld : a_byte_vld;
  assign o_done     = sel ? b_done     : a_done;
  assign o_crc_ok   = sel ? b_crc_ok   : a_crc_ok;
  assign o_crc_err  = sel ? b_crc_err  : a_crc_err;
  assign o_end_err  = sel ? b_end_err  : a_end_err;
  assign o_timeout  = sel ? b_timeout  : a_timeout;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_q[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (o_byte_vld) got_q.push_back(o_byte_out);
    if (o_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-at-a-time CRC16/XMODEM reference.
  function automatic logic [15:0] model_crc(input logic [7:0] d[$]);
    logic [15:0] c = 16'h0000;
    foreach (d[i]) begin
      c = c ^ {d[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     {31'd0, o_busy},     32'd0);
    check({tag, "_byte_out"}, {24'd0, o_byte_out}, 32'd0);
    check({tag, "_byte_vld"}, {31'd0, o_byte_vld}, 32'd0);
    check({tag, "_done"},     {31'd0, o_done},     32'd0);
    check({tag, "_crc_ok"},   {31'd0, o_crc_ok},   32'd0);
    check({tag, "_crc_err"},  {31'd0, o_crc_err},  32'd0);
    check({tag, "_end_err"},  {31'd0, o_end_err},  32'd0);
    check({tag, "_timeout"},  {31'd0, o_timeout},  32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (sel) rx_start_b = 1'b1; else rx_start_a = 1'b1;
    @(negedge clk);
    rx_start_a = 1'b0;
    rx_start_b = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int mingap, input int maxgap);
    int gap;
    gap = (maxgap == 0) ? 0 : int'($urandom_range(maxgap, mingap));
    @(negedge clk);
    dat_i = b;
    bit_en = 1'b1;
    if (gap > 0) begin
      @(negedge clk);
      bit_en = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  // abort_at >= 0 resets the DUT halfway through that byte instead of finishing.
  task automatic run_block(input string tag, input logic [7:0] d[$], input logic [15:0] tx_crc,
                           input logic endb, input int mingap, input int maxgap,
                           input bit repulse, input int abort_at);
    logic [15:0] exp_crc;
    got_q.delete();
    done_cnt = 0;
    pulse_start();
    check({tag, "_busy_rise"}, {31'd0, o_busy}, 32'd1);
    check({tag, "_flags_clr"}, {28'd0, o_crc_ok, o_crc_err, o_end_err, o_timeout}, 32'd0);
    send_bit(1'b0, mingap, maxgap);
    foreach (d[i]) begin
      if (repulse && i == d.size() / 2) begin
        @(negedge clk);
        bit_en = 1'b0;
        if (sel) rx_start_b = 1'b1; else rx_start_a = 1'b1;
        @(negedge clk);
        rx_start_a = 1'b0;
        rx_start_b = 1'b0;
      end
      for (int k = 7; k >= 0; k--) begin
        if (i == abort_at && k == 3) begin
          @(negedge clk);
          bit_en = 1'b0;
          #2 rst = 1'b0;
          #1 check_all_zero({tag, "_async_rst"});
          repeat (3) @(negedge clk);
          check({tag, "_no_done"}, done_cnt, 32'd0);
          rst = 1'b1;
          return;
        end
        send_bit(d[i][k], mingap, maxgap);
      end
    end
    for (int k = 15; k >= 0; k--) send_bit(tx_crc[k], mingap, maxgap);
    send_bit(endb, mingap, maxgap);
    @(negedge clk);
    bit_en = 1'b0;
    dat_i = 1'b1;
    repeat (3) @(negedge clk);
    exp_crc = model_crc(d);
    check({tag, "_done_cnt"}, done_cnt, 32'd1);
    check({tag, "_busy_fall"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_nbytes"}, got_q.size(), d.size());
    foreach (d[i]) begin
      if (i < got_q.size()) check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, d[i]});
    end
    check({tag, "_crc_ok"},  {31'd0, o_crc_ok},  {31'd0, (tx_crc == exp_crc) && endb});
    check({tag, "_crc_err"}, {31'd0, o_crc_err}, {31'd0, tx_crc != exp_crc});
    check({tag, "_end_err"}, {31'd0, o_end_err}, {31'd0, !endb});
    check({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
    $display("block %s bytes=%0d tx_crc=%h model_crc=%h end=%0d crc_ok=%0d crc_err=%0d end_err=%0d",
             tag, got_q.size(), tx_crc, exp_crc, endb, o_crc_ok, o_crc_err, o_end_err);
  endtask

  initial begin
    logic [7:0] blk[$];
    logic [7:0] ascii[$];
    logic [15:0] c;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1 check_all_zero("reset");
    end
    @(negedge clk);
    rst = 1'b1;

    // 512 bytes of 0xFF, continuous strobes.
    sel = 1'b0;
    blk.delete();
    for (int i = 0; i < 512; i++) blk.push_back(8'hFF);
    run_block("ff512", blk, 16'h7FA1, 1'b1, 0, 0, 1'b0, -1);
    check("ff512_spec_ok", {31'd0, o_crc_ok}, 32'd1);

    sel = 1'b1;
    for (int i = 0; i < 9; i++) ascii.push_back(8'(8'h31 + i));
    run_block("ascii_good", ascii, 16'h31C3, 1'b1, 0, 0, 1'b0, -1);
    check("ascii_spec_ok", {31'd0, o_crc_ok}, 32'd1);
    run_block("ascii_badcrc", ascii, 16'h31C2, 1'b1, 0, 0, 1'b0, -1);
    check("ascii_spec_err", {31'd0, o_crc_err}, 32'd1);
    run_block("ascii_badend", ascii, 16'h31C3, 1'b0, 0, 0, 1'b0, -1);
    check("ascii_spec_enderr", {31'd0, o_end_err}, 32'd1);

    // Timeout: DAT0 idles high for exactly TIMEOUT strobes.
    done_cnt = 0;
    pulse_start();
    check("to_busy", {31'd0, o_busy}, 32'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("to_early_done", {31'd0, o_done}, 32'd0);
      dat_i = 1'b1;
      bit_en = 1'b1;
    end
    @(negedge clk);
    bit_en = 1'b0;
    check("to_done", {31'd0, o_done}, 32'd1);
    check("to_flag", {31'd0, o_timeout}, 32'd1);
    check("to_busy_fall", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    check("to_done_pulse", {31'd0, o_done}, 32'd0);
    $display("timeout done_cnt=%0d timeout=%0d", done_cnt, o_timeout);

    // Sparse strobes with a rejected mid-block re-start.
    run_block("gap_ascii", ascii, 16'h31C3, 1'b1, 3, 5, 1'b1, -1);
    for (int r = 0; r < 4; r++) begin
      blk.delete();
      for (int i = 0; i < 9; i++) blk.push_back(8'($urandom));
      c = model_crc(blk);
      if (r[0]) c = c ^ (16'h1 << $urandom_range(15, 0));
      run_block($sformatf("rand%0d", r), blk, c, (r != 2), (r < 2) ? 3 : 0, (r < 2) ? 5 : 0,
                r[0] == 1'b0, -1);
    end

    // Reset mid-DATA, then a clean block.
    run_block("abort", ascii, 16'h31C3, 1'b1, 0, 0, 1'b0, 3);
    run_block("after_abort", ascii, 16'h31C3, 1'b1, 0, 0, 1'b0, -1);
    check("after_abort_ok", {31'd0, o_crc_ok}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
